// File: rtl/sfifo_stream_reader.sv
// sfifo_stream_reader: drains an sfifo read port into a registered
// valid/ready stream with packet framing. The most recently popped word is
// held in a pending register until it is known whether it ends a packet.
// A packet ends after PKTLEN words, or after TIMEOUT idle cycles with an
// empty FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// P empty | no word held back; next pop starts a packet at index 0
// P full  | one word held, waiting for a successor, PKTLEN or timeout
// O full  | word presented downstream, held stable until accepted
module sfifo_stream_reader #(
    parameter int BW      = 8,
    parameter int PKTLEN  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_fifo_empty,
    input  logic [BW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [BW-1:0] o_data,
    output logic          o_last
);

    localparam int IW = (PKTLEN > 1) ? $clog2(PKTLEN) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PKTLEN - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic          p_valid_q, p_valid_d;
    logic [BW-1:0] p_data_q, p_data_d;
    logic [IW-1:0] p_idx_q, p_idx_d;
    logic          o_valid_q, o_valid_d;
    logic [BW-1:0] o_data_q, o_data_d;
    logic          o_last_q, o_last_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;

    logic can_load;
    logic fifo_rd;
    logic rel_a, rel_b, rel_c;
    logic rel_go;
    logic rel_last;

    // Handshake and release decode; a successor pop beats a timeout, so a
    // word only closes by timeout if nothing follows it on that edge.
    always_comb begin
        can_load = !o_valid_q || i_ready;
        fifo_rd  = !i_reset && !i_fifo_empty && (!p_valid_q || can_load);
        rel_a    = p_valid_q && can_load && (p_idx_q == IDX_LAST);
        rel_b    = p_valid_q && can_load && fifo_rd;
        rel_c    = p_valid_q && can_load && (idle_cnt_q == CNT_MAX);
        rel_go   = rel_a || rel_b || rel_c;
        rel_last = rel_a || !rel_b;
    end

    // Next-state for the pending register, output register and idle counter.
    always_comb begin
        p_valid_d  = p_valid_q;
        p_data_d   = p_data_q;
        p_idx_d    = p_idx_q;
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        o_last_d   = o_last_q;
        idle_cnt_d = idle_cnt_q;

        if (fifo_rd) begin
            p_valid_d = 1'b1;
            p_data_d  = i_fifo_data;
            // A pop with P full always releases P, so rel_last is meaningful.
            if (!p_valid_q || rel_last)
                p_idx_d = '0;
            else
                p_idx_d = p_idx_q + IW'(1);
        end else if (rel_go) begin
            p_valid_d = 1'b0;
        end

        if (rel_go) begin
            o_valid_d = 1'b1;
            o_data_d  = p_data_q;
            o_last_d  = rel_last;
        end else if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
        end

        // Saturates while O is blocked so the close happens as soon as O frees.
        if (fifo_rd || !i_fifo_empty)
            idle_cnt_d = '0;
        else if (p_valid_q && (idle_cnt_q != CNT_MAX))
            idle_cnt_d = idle_cnt_q + CW'(1);
    end

    // State registers; reset discards any held or presented word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            p_valid_q  <= 1'b0;
            p_data_q   <= '0;
            p_idx_q    <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            p_valid_q  <= p_valid_d;
            p_data_q   <= p_data_d;
            p_idx_q    <= p_idx_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign o_fifo_rd = fifo_rd;
    assign o_valid   = o_valid_q;
    assign o_data    = o_data_q;
    assign o_last    = o_last_q;

endmodule

// File: tb/tb_sfifo_stream_reader.sv
// Scoreboard bench for sfifo_stream_reader: a queue models the sfifo, the
// expected beat stream is derived from packet rules when words are issued,
// and a negedge monitor compares every accepted beat.
module tb_sfifo_stream_reader;

    localparam int BW      = 8;
    localparam int PKTLEN  = 4;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [BW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty, fifo_empty1;
    logic [BW-1:0] fifo_data, fifo_data1;
    logic          fifo_rd, fifo_rd1;
    logic          o_valid, o_valid1;
    logic          ready = 1'b1;
    logic          ready1 = 1'b1;
    logic [BW-1:0] o_data, o_data1;
    logic          o_last, o_last1;

    beat_t         exp_q[$];
    beat_t         exp1_q[$];
    logic [BW-1:0] fifo_q[$];
    logic [BW-1:0] fifo1_q[$];
    logic [BW-1:0] burst_q[$];
    int            beat_cyc_q[$];
    int            beat1_cyc_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int model_idx = 0;
    bit last_pop, last_pop1;

    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data;
    logic          prev_last;

    sfifo_stream_reader #(.BW(BW), .PKTLEN(PKTLEN), .TIMEOUT(TIMEOUT)) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd    (fifo_rd),
        .o_valid      (o_valid),
        .i_ready      (ready),
        .o_data       (o_data),
        .o_last       (o_last)
    );

    sfifo_stream_reader #(.BW(BW), .PKTLEN(1), .TIMEOUT(TIMEOUT)) u_dut1 (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_fifo_empty (fifo_empty1),
        .i_fifo_data  (fifo_data1),
        .o_fifo_rd    (fifo_rd1),
        .o_valid      (o_valid1),
        .i_ready      (ready1),
        .o_data       (o_data1),
        .o_last       (o_last1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic refresh();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_data   = fifo_empty ? '0 : fifo_q[0];
        fifo_empty1 = (fifo1_q.size() == 0);
        fifo_data1  = fifo_empty1 ? '0 : fifo1_q[0];
    endtask

    // One clock: sample the pop requests mid-cycle, apply them after the edge.
    task automatic step();
        @(negedge clk);
        last_pop  = fifo_rd;
        last_pop1 = fifo_rd1;
        @(posedge clk);
        #1;
        if (last_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (last_pop1 && fifo1_q.size() > 0) void'(fifo1_q.pop_front());
        refresh();
    endtask

    // Reference packetiser: a word closes its packet if it is the PKTLEN-th
    // word, or if it is the last word before an empty gap longer than TIMEOUT.
    task automatic expect_burst(input int gap);
        beat_t b;
        for (int i = 0; i < burst_q.size(); i++) begin
            b.d = burst_q[i];
            b.l = (model_idx == PKTLEN - 1) || ((i == burst_q.size() - 1) && (gap > TIMEOUT));
            exp_q.push_back(b);
            fifo_q.push_back(burst_q[i]);
            model_idx = b.l ? 0 : model_idx + 1;
        end
        refresh();
    endtask

    task automatic run_episode(input int k, input int gap, input int ready_pct);
        int guard = 0;
        burst_q.delete();
        for (int i = 0; i < k; i++) burst_q.push_back(BW'($urandom_range(0, 255)));
        expect_burst(gap);
        while (fifo_q.size() != 0 && guard < 500) begin
            ready = ($urandom_range(0, 99) < ready_pct);
            step();
            guard++;
        end
        if (guard >= 500) fail_now("episode_drain", fifo_q.size(), 0);
        ready = 1'b1;
        for (int i = 0; i < gap; i++) step();
    endtask

    task automatic wait_drain();
        int guard = 0;
        ready = 1'b1;
        while ((exp_q.size() != 0 || exp1_q.size() != 0 || fifo_q.size() != 0 ||
                fifo1_q.size() != 0) && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) fail_now("drain_timeout", exp_q.size() + exp1_q.size(), 0);
        repeat (2) step();
    endtask

    // Monitor: compare every accepted beat and the hold rule during stalls.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {o_valid, o_last, o_data}, {1'b1, prev_last, prev_data});
            if (o_valid && ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_beat", int'(o_data), -1);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", o_data, b.d);
                    check("beat_last", o_last, b.l);
                end
                beat_cyc_q.push_back(cyc);
            end
            prev_stall = o_valid && !ready;
            prev_data  = o_data;
            prev_last  = o_last;
            if (o_valid1 && ready1) begin
                if (exp1_q.size() == 0) begin
                    fail_now("extra_beat_p1", int'(o_data1), -1);
                end else begin
                    b = exp1_q.pop_front();
                    check("p1_data", o_data1, b.d);
                    check("p1_last", o_last1, b.l);
                end
                beat1_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        int c0, t0, sel, g;
        beat_t b;
        refresh();
        #2 rst = 1'b1;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);

        // Preloaded FIFO, one full packet at full throughput.
        burst_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        expect_burst(TIMEOUT + 5);
        #1;
        check("rst_rd", fifo_rd, 0);
        step();
        step();
        check("rst_rd_hold", fifo_rd, 0);
        rst = 1'b0;
        c0 = cyc;
        beat_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_rd_burst", last_pop, 1);
        end
        wait_drain();
        check("t1_beats", beat_cyc_q.size(), 4);
        for (int i = 0; i < 4 && i < beat_cyc_q.size(); i++)
            check("t1_beat_cycle", beat_cyc_q[i], c0 + 2 + i);

        // Partial packet closed by timeout.
        beat_cyc_q.delete();
        t0 = cyc;
        burst_q = '{8'hA0, 8'hA1};
        expect_burst(TIMEOUT + 5);
        wait_drain();
        check("t2_beats", beat_cyc_q.size(), 2);
        if (beat_cyc_q.size() == 2) begin
            check("t2_a0_cycle", beat_cyc_q[0], t0 + 2);
            check("t2_a1_cycle", beat_cyc_q[1], t0 + 3 + TIMEOUT);
        end

        // Data returns exactly at the timeout cycle, then one cycle later.
        run_episode(2, TIMEOUT, 100);
        run_episode(3, TIMEOUT + 1, 100);
        run_episode(1, TIMEOUT + 5, 100);
        wait_drain();

        // Mid-stream stall with P and O both full.
        burst_q.delete();
        for (int i = 0; i < 8; i++) burst_q.push_back(BW'(i));
        expect_burst(TIMEOUT + 5);
        ready = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_rd_stalled", last_pop, 0);
        end
        wait_drain();

        // Randomised episodes.
        for (int e = 0; e < 40; e++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: g = 0;
                1: g = $urandom_range(1, TIMEOUT - 1);
                2: g = TIMEOUT;
                3: g = TIMEOUT + 1;
                default: g = TIMEOUT + $urandom_range(2, 6);
            endcase
            if (e == 39) g = TIMEOUT + 5;
            run_episode($urandom_range(1, 7), g, 60);
        end
        wait_drain();

        // Asynchronous reset while a beat is stalled.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(BW'(8'hC0 + i));
        refresh();
        repeat (3) step();
        check("t5_valid_before", o_valid, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_valid_async", o_valid, 0);
        check("t5_last_async", o_last, 0);
        check("t5_rd_async", fifo_rd, 0);
        @(posedge clk);
        #1;
        check("t5_data_rst", o_data, 0);
        check("t5_rd_rst", fifo_rd, 0);
        step();
        step();
        rst = 1'b0;
        ready = 1'b1;
        model_idx = 0;
        burst_q = fifo_q;
        fifo_q.delete();
        burst_q.push_back(8'hC5);
        expect_burst(TIMEOUT + 5);
        wait_drain();

        // PKTLEN=1 instance: no hold-back, every beat last.
        beat1_cyc_q.delete();
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            b.d = BW'(8'h50 + i);
            b.l = 1'b1;
            exp1_q.push_back(b);
            fifo1_q.push_back(b.d);
        end
        refresh();
        wait_drain();
        check("t6_beats", beat1_cyc_q.size(), 3);
        for (int i = 0; i < 3 && i < beat1_cyc_q.size(); i++)
            check("t6_beat_cycle", beat1_cyc_q[i], t0 + 2 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
